sd_spi_responder: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 29 ++
 rtl/sd_spi_responder_crc16.sv | 33 +++
 rtl/sd_spi_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;

    // CCS=1: block addressing, powered up
    localparam logic [31:0] OCR = 32'hC0FF_8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_NCR,
        S_RESP,
        S_NAC,
        S_TOKEN,
        S_DATA,
        S_CRC
    } sd_state_t;

endpackage

// File: rtl/sd_spi_responder_crc16.sv
// Byte-parallel CRC16-CCITT (poly 0x1021, init 0) with synchronous clear and enable.
module sd_crc16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ d[7 - i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Accumulate one byte per enable; clear has priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= crc_byte(crc, data);
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes commands, answers R1/R3/R7 and serves CMD17 block reads.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INIT_POLLS = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              in_idle
);

    localparam logic [7:0] POLL_LIM = 8'(INIT_POLLS);

    logic [2:0]        sck_q;
    logic [1:0]        cs_q;
    logic [1:0]        mosi_q;
    logic              sck_rise, sck_fall, cs_hi, mosi_b;

    sd_state_t         state;
    logic [2:0]        bit_cnt;
    logic [5:0]        cmd_cnt;
    logic [37:0]       cmd_sr;
    logic [9:0]        byte_cnt;
    logic [39:0]       resp_sr;
    logic              resp_long;
    logic              rd_go;
    logic [ADDR_W-1:0] base;
    logic [7:0]        tx_sr;
    logic [7:0]        pf;
    logic              rd_q;
    logic [7:0]        polls;
    logic              app_flag;

    logic [5:0]        cmd_idx;
    logic [31:0]       cmd_arg;
    logic [7:0]        r1;
    logic [39:0]       d_resp;
    logic              d_long, d_rd, d_idle, d_app;
    logic [7:0]        d_polls;
    logic [7:0]        tx_next;
    logic [15:0]       crc;
    logic              crc_clr, crc_en;

    // Two-flop synchronisers; the third sck flop provides edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '1;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_hi    = cs_q[1];
    assign mosi_b   = mosi_q[1];

    // Only index and argument are retained from the frame; CRC7 and stop bit are ignored
    assign cmd_idx = cmd_sr[37:32];
    assign cmd_arg = cmd_sr[31:0];

    // Command decode: response bytes and next persistent card state
    always_comb begin
        r1      = {7'b0, in_idle};
        d_resp  = {r1 | R1_ILLEGAL, 32'hFFFF_FFFF};
        d_long  = 1'b0;
        d_rd    = 1'b0;
        d_idle  = in_idle;
        d_polls = polls;
        d_app   = 1'b0;
        case (cmd_idx)
            CMD0: begin
                d_idle         = 1'b1;
                d_polls        = '0;
                d_resp[39:32]  = R1_IDLE;
            end
            CMD8: begin
                d_resp = {r1, 16'h0000, 4'h0, cmd_arg[11:8], cmd_arg[7:0]};
                d_long = 1'b1;
            end
            CMD55: begin
                d_app         = 1'b1;
                d_resp[39:32] = r1;
            end
            CMD41: begin
                if (app_flag) begin
                    if (polls < POLL_LIM) begin
                        d_polls       = polls + 8'd1;
                        d_resp[39:32] = R1_IDLE;
                    end else begin
                        d_idle        = 1'b0;
                        d_resp[39:32] = 8'h00;
                    end
                end
            end
            CMD58: begin
                d_resp = {r1, OCR};
                d_long = 1'b1;
            end
            CMD17: begin
                if (in_idle) begin
                    d_resp[39:32] = R1_IDLE | R1_ILLEGAL;
                end else begin
                    d_resp[39:32] = 8'h00;
                    d_rd          = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Byte to load into the shifter at the start of the next byte slot
    always_comb begin
        tx_next = 8'hFF;
        case (state)
            S_RESP:  tx_next = resp_sr[39:32];
            S_TOKEN: tx_next = DATA_TOKEN;
            S_DATA:  tx_next = pf;
            S_CRC:   tx_next = byte_cnt[0] ? crc[7:0] : crc[15:8];
            default: tx_next = 8'hFF;
        endcase
    end

    assign crc_clr = (state == S_NAC);
    assign crc_en  = (state == S_DATA) && sck_fall && (bit_cnt == 3'd0) && !cs_hi;

    sd_crc16 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (crc_clr),
        .en   (crc_en),
        .data (pf),
        .crc  (crc)
    );

    // Protocol FSM: command capture on rising SCK, response/data shifting on falling SCK
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            cmd_cnt   <= '0;
            cmd_sr    <= '0;
            byte_cnt  <= '0;
            resp_sr   <= '1;
            resp_long <= 1'b0;
            rd_go     <= 1'b0;
            base      <= '0;
            tx_sr     <= '1;
            pf        <= '0;
            rd_q      <= 1'b0;
            polls     <= '0;
            app_flag  <= 1'b0;
            in_idle   <= 1'b1;
            miso      <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else if (cs_hi) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            cmd_cnt   <= '0;
            byte_cnt  <= '0;
            resp_long <= 1'b0;
            rd_go     <= 1'b0;
            rd_q      <= 1'b0;
            miso      <= 1'b1;
            mem_rd    <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            rd_q   <= mem_rd;
            if (rd_q)
                pf <= mem_rdata;
            case (state)
                S_IDLE: begin
                    if (sck_fall)
                        miso <= 1'b1;
                    if (sck_rise && !mosi_b) begin
                        state   <= S_CMD;
                        cmd_cnt <= 6'd1;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        // frame bits 2..39 carry the index and argument
                        if (cmd_cnt >= 6'd2 && cmd_cnt <= 6'd39)
                            cmd_sr <= {cmd_sr[36:0], mosi_b};
                        cmd_cnt <= cmd_cnt + 6'd1;
                        if (cmd_cnt == 6'd47) begin
                            state     <= S_NCR;
                            bit_cnt   <= '0;
                            byte_cnt  <= '0;
                            resp_sr   <= d_resp;
                            resp_long <= d_long;
                            rd_go     <= d_rd;
                            in_idle   <= d_idle;
                            polls     <= d_polls;
                            app_flag  <= d_app;
                            if (d_rd)
                                base <= ADDR_W'({cmd_arg, 9'b0});
                        end
                    end
                end
                default: begin
                    if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            miso  <= tx_next[7];
                            tx_sr <= {tx_next[6:0], 1'b1};
                            if (state == S_RESP)
                                resp_sr <= {resp_sr[31:0], 8'hFF};
                            // prefetch the following byte while this one shifts out
                            if (state == S_DATA && byte_cnt != 10'd511) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= base + ADDR_W'(byte_cnt) + ADDR_W'(1);
                            end
                        end else begin
                            miso  <= tx_sr[7];
                            tx_sr <= {tx_sr[6:0], 1'b1};
                        end
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 10'd1;
                            case (state)
                                S_NCR: begin
                                    state    <= S_RESP;
                                    byte_cnt <= '0;
                                end
                                S_RESP: begin
                                    if (!resp_long || byte_cnt == 10'd4) begin
                                        byte_cnt <= '0;
                                        state    <= rd_go ? S_NAC : S_IDLE;
                                    end
                                end
                                S_NAC: begin
                                    state    <= S_TOKEN;
                                    byte_cnt <= '0;
                                    mem_rd   <= 1'b1;
                                    mem_addr <= base;
                                end
                                S_TOKEN: begin
                                    state    <= S_DATA;
                                    byte_cnt <= '0;
                                end
                                S_DATA: begin
                                    if (byte_cnt == 10'd511) begin
                                        state    <= S_CRC;
                                        byte_cnt <= '0;
                                    end
                                end
                                S_CRC: begin
                                    if (byte_cnt == 10'd1) begin
                                        state    <= S_IDLE;
                                        byte_cnt <= '0;
                                        rd_go    <= 1'b0;
                                    end
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI host tasks, byte scoreboard and memory-address scoreboard.
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        in_idle;

    int          errors = 0;
    int          checks = 0;
    int          rd_count = 0;
    int          rd_snap;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] exp_addr;
    logic [15:0] ref_crc;

    sd_spi_responder #(.ADDR_W(32), .INIT_POLLS(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .in_idle   (in_idle)
    );

    always #5 clk = ~clk;

    // Flash model: byte k holds k[7:0], data registered one clk after the strobe
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

    // Every read strobe must match the next expected address
    always @(negedge clk) begin
        if (rstn && mem_rd) begin
            rd_count++;
            checks++;
            assert (addr_q.size() != 0)
            else begin
                errors++;
                $error("FAIL mem_rd_unexpected: got read at %h, expected no read", mem_addr);
            end
            if (addr_q.size() != 0) begin
                exp_addr = addr_q.pop_front();
                checks++;
                assert (mem_addr === exp_addr)
                else begin
                    errors++;
                    $error("FAIL mem_addr: got %h expected %h", mem_addr, exp_addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One SPI mode-0 byte: MOSI set while SCK low, MISO sampled at rising SCK
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            sck = 1'b1;
            rx[i] = miso;
            #80;
            sck = 1'b0;
            #40;
        end
        mosi = 1'b1;
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0] rx;
        xfer({2'b01, idx}, rx);
        xfer(arg[31:24], rx);
        xfer(arg[23:16], rx);
        xfer(arg[15:8], rx);
        xfer(arg[7:0], rx);
        xfer(8'h95, rx);
    endtask

    task automatic drain(input string tag);
        logic [7:0] rx;
        logic [7:0] e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            xfer(8'hFF, rx);
            chk(tag, 32'(rx), 32'(e));
        end
    endtask

    task automatic push5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(e);
    endtask

    // Full CMD17 data phase starting at byte address base_a
    task automatic push_block(input logic [31:0] base_a);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int k = 0; k < 512; k++) begin
            logic [31:0] kk;
            kk = base_a + 32'(k);
            exp_q.push_back(kk[7:0]);
            addr_q.push_back(kk);
        end
        exp_q.push_back(ref_crc[15:8]);
        exp_q.push_back(ref_crc[7:0]);
        exp_q.push_back(8'hFF);
    endtask

    // Bit-serial CRC16-CCITT reference over the 0..FF,0..FF pattern
    function automatic logic [15:0] calc_crc();
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < 512; k++) begin
            d = k[7:0];
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    initial begin
        ref_crc = calc_crc();
        #23;
        chk("reset_miso", 32'(miso), 32'd1);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_in_idle", 32'(in_idle), 32'd1);
        #40 rstn = 1'b1;
        #100 cs_n = 1'b0;
        #100;

        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        drain("idle_line");

        send_cmd(6'd0, 32'h0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        drain("cmd0");
        chk("cmd0_in_idle", 32'(in_idle), 32'd1);

        send_cmd(6'd8, 32'h0000_01AA);
        exp_q.push_back(8'hFF);
        push5(8'h01, 8'h00, 8'h00, 8'h01, 8'hAA);
        drain("cmd8");

        send_cmd(6'd17, 32'd2);
        push5(8'hFF, 8'h05, 8'hFF, 8'hFF, 8'hFF);
        drain("cmd17_idle");

        send_cmd(6'd5, 32'h0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h05);
        drain("cmd5");

        send_cmd(6'd41, 32'h4000_0000);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h05);
        drain("cmd41_noapp");

        for (int n = 0; n < 3; n++) begin
            send_cmd(6'd55, 32'h0);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'h01);
            drain("cmd55");
            send_cmd(6'd41, 32'h4000_0000);
            exp_q.push_back(8'hFF);
            exp_q.push_back((n < 2) ? 8'h01 : 8'h00);
            drain("acmd41");
        end
        chk("init_in_idle", 32'(in_idle), 32'd0);

        send_cmd(6'd58, 32'h0);
        exp_q.push_back(8'hFF);
        push5(8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00);
        drain("cmd58");

        send_cmd(6'd17, 32'd2);
        push_block(32'h400);
        drain("cmd17_block");
        #100;
        chk("block_addr_left", 32'(addr_q.size()), 32'd0);

        // Abort after 100 data bytes; byte 100 is shifting and byte 101 has been requested
        send_cmd(6'd17, 32'd2);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int k = 0; k < 100; k++) exp_q.push_back(8'(k));
        for (int k = 0; k < 102; k++) addr_q.push_back(32'h400 + 32'(k));
        drain("abort_prefix");
        #100;
        cs_n = 1'b1;
        #60;
        chk("abort_miso", 32'(miso), 32'd1);
        chk("abort_mem_rd", 32'(mem_rd), 32'd0);
        rd_snap = rd_count;
        #2000;
        chk("abort_no_reads", 32'(rd_count), 32'(rd_snap));
        chk("abort_addr_left", 32'(addr_q.size()), 32'd0);
        addr_q.delete();
        cs_n = 1'b0;
        #200;

        send_cmd(6'd17, 32'd2);
        push_block(32'h400);
        drain("cmd17_after_abort");
        #100;
        chk("reread_addr_left", 32'(addr_q.size()), 32'd0);

        // Reset in the middle of a command frame
        begin
            logic [7:0] rx;
            xfer(8'h40, rx);
            xfer(8'h00, rx);
        end
        #30 rstn = 1'b0;
        #1;
        chk("midreset_miso", 32'(miso), 32'd1);
        chk("midreset_mem_rd", 32'(mem_rd), 32'd0);
        chk("midreset_mem_addr", mem_addr, 32'd0);
        chk("midreset_in_idle", 32'(in_idle), 32'd1);
        #50 rstn = 1'b1;
        #100;
        send_cmd(6'd0, 32'h0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01);
        drain("cmd0_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
